feature_buf_ctrl: RTL and testbench

- Ping-pong scheduler for the two-bank on-chip input-feature memory.
- Sequences the feature fetch engine, which fills a bank from external memory, against the convolution engine, which drains a bank, tile by tile, for one layer.
- Tracks the state of each bank and issues start pulses to each engine only when that is safe.
- Drives bank select to both engines and reports layer completion.

---
 rtl/feature_pkg.sv | 33 +++
 rtl/buf_bank_state.sv | 46 ++++
 rtl/feature_buf_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_feature_buf_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/feature_pkg.sv
// Shared types for the two-bank input-feature ping-pong scheduler.
package feature_pkg;

   localparam int CNT_W_DFLT  = 16;
   localparam int SIZE_W_DFLT = 8;

   typedef enum logic [1:0] {
      BANK_EMPTY = 2'd0,
      BANK_FILL  = 2'd1,
      BANK_FULL  = 2'd2,
      BANK_USE   = 2'd3
   } bank_state_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } top_state_e;

   // Completion events only move a bank out of its in-flight state.
   function automatic bank_state_e bank_after_done(input bank_state_e cur,
                                                   input logic        filled,
                                                   input logic        released);
      bank_state_e nxt;
      case (cur)
         BANK_FILL: nxt = filled   ? BANK_FULL  : BANK_FILL;
         BANK_USE:  nxt = released ? BANK_EMPTY : BANK_USE;
         default:   nxt = cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/buf_bank_state.sv
// State of one feature bank; exposes the state after this cycle's completions
// so the scheduler can reissue to a bank in the same edge it is released.
module buf_bank_state
   import feature_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        fill_i,
   input  logic        filled_i,
   input  logic        use_i,
   input  logic        release_i,
   output bank_state_e state_eff_o
);

   bank_state_e state_q;
   bank_state_e state_d;
   bank_state_e eff_s;

   // Apply completions first, then any new issue against the updated state.
   always_comb begin
      eff_s   = bank_after_done(state_q, filled_i, release_i);
      state_d = eff_s;
      if (clr_i) begin
         state_d = BANK_EMPTY;
      end else if (fill_i && (eff_s == BANK_EMPTY)) begin
         state_d = BANK_FILL;
      end else if (use_i && (eff_s == BANK_FULL)) begin
         state_d = BANK_USE;
      end else begin
         state_d = eff_s;
      end
   end

   // Bank state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BANK_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_eff_o = eff_s;

endmodule

// File: rtl/feature_buf_ctrl.sv
// Ping-pong scheduler: fetch engine fills one bank while the compute engine
// drains the other, tile by tile, for one layer.
module feature_buf_ctrl
   import feature_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DFLT,
   parameter int SIZE_W = SIZE_W_DFLT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_tiles,
   input  logic [SIZE_W-1:0] feature_size,
   output logic              fetch_start,
   output logic              fetch_bank,
   output logic [SIZE_W-1:0] fetch_size,
   input  logic              fetch_done,
   output logic              comp_start,
   output logic              comp_bank,
   input  logic              comp_done,
   output logic              busy,
   output logic              layer_done,
   output logic              err
);

   top_state_e        state_q, state_d;
   logic [CNT_W-1:0]  num_tiles_q, num_tiles_d;
   logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
   logic [CNT_W-1:0]  comp_cnt_q, comp_cnt_d;
   logic              fetch_ptr_q, fetch_ptr_d;
   logic              comp_ptr_q, comp_ptr_d;
   logic              fetch_fly_q, fetch_fly_d;
   logic              comp_fly_q, comp_fly_d;
   logic              err_q, err_d;
   logic              fetch_start_q, fetch_start_d;
   logic              fetch_bank_q, fetch_bank_d;
   logic [SIZE_W-1:0] fetch_size_q, fetch_size_d;
   logic              comp_start_q, comp_start_d;
   logic              comp_bank_q, comp_bank_d;
   logic              busy_q, busy_d;
   logic              layer_done_q, layer_done_d;

   logic              fetch_ok_s, comp_ok_s, spurious_s;
   logic              fetch_ptr_e_s, comp_ptr_e_s;
   logic [CNT_W-1:0]  comp_cnt_e_s;
   logic              run_s, accept_s, zero_s, last_s;
   logic              fetch_issue_s, comp_issue_s;
   logic [1:0]        filled_s, release_s, fill_s, use_s;
   bank_state_e       bank0_s, bank1_s, fetch_tgt_s, comp_tgt_s;

   buf_bank_state u_bank0 (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (accept_s),
      .fill_i      (fill_s[0]),
      .filled_i    (filled_s[0]),
      .use_i       (use_s[0]),
      .release_i   (release_s[0]),
      .state_eff_o (bank0_s)
   );

   buf_bank_state u_bank1 (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (accept_s),
      .fill_i      (fill_s[1]),
      .filled_i    (filled_s[1]),
      .use_i       (use_s[1]),
      .release_i   (release_s[1]),
      .state_eff_o (bank1_s)
   );

   // Decode engine events; issue decisions look at the post-completion view.
   always_comb begin
      fetch_ok_s    = fetch_done & fetch_fly_q;
      comp_ok_s     = comp_done & comp_fly_q;
      spurious_s    = (fetch_done & ~fetch_fly_q) | (comp_done & ~comp_fly_q);
      fetch_ptr_e_s = fetch_ptr_q ^ fetch_ok_s;
      comp_ptr_e_s  = comp_ptr_q ^ comp_ok_s;
      comp_cnt_e_s  = comp_cnt_q + {{(CNT_W-1){1'b0}}, comp_ok_s};
      run_s         = (state_q == ST_RUN);
      accept_s      = (state_q == ST_IDLE) & start & (num_tiles != {CNT_W{1'b0}});
      zero_s        = (state_q == ST_IDLE) & start & (num_tiles == {CNT_W{1'b0}});
      last_s        = run_s & comp_ok_s & (comp_cnt_e_s == num_tiles_q);
      fetch_tgt_s   = fetch_ptr_e_s ? bank1_s : bank0_s;
      comp_tgt_s    = comp_ptr_e_s ? bank1_s : bank0_s;
      fetch_issue_s = run_s & ~last_s & ~(fetch_fly_q & ~fetch_ok_s)
                      & (fetch_cnt_q < num_tiles_q) & (fetch_tgt_s == BANK_EMPTY);
      comp_issue_s  = run_s & ~last_s & ~(comp_fly_q & ~comp_ok_s)
                      & (comp_tgt_s == BANK_FULL);
      filled_s      = {fetch_ok_s & fetch_bank_q, fetch_ok_s & ~fetch_bank_q};
      release_s     = {comp_ok_s & comp_bank_q, comp_ok_s & ~comp_bank_q};
      fill_s        = {fetch_issue_s & fetch_ptr_e_s, fetch_issue_s & ~fetch_ptr_e_s};
      use_s         = {comp_issue_s & comp_ptr_e_s, comp_issue_s & ~comp_ptr_e_s};
   end

   // Top FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: state_d = accept_s ? ST_RUN : ST_IDLE;
         ST_RUN:  state_d = last_s ? ST_FIN : ST_RUN;
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Counters, pointers, in-flight flags and registered outputs.
   always_comb begin
      num_tiles_d   = num_tiles_q;
      fetch_size_d  = fetch_size_q;
      fetch_cnt_d   = fetch_cnt_q + {{(CNT_W-1){1'b0}}, fetch_issue_s};
      comp_cnt_d    = comp_cnt_e_s;
      fetch_ptr_d   = fetch_ptr_e_s;
      comp_ptr_d    = comp_ptr_e_s;
      fetch_fly_d   = (fetch_fly_q & ~fetch_ok_s) | fetch_issue_s;
      comp_fly_d    = (comp_fly_q & ~comp_ok_s) | comp_issue_s;
      fetch_start_d = fetch_issue_s;
      fetch_bank_d  = fetch_issue_s ? fetch_ptr_e_s : fetch_bank_q;
      comp_start_d  = comp_issue_s;
      comp_bank_d   = comp_issue_s ? comp_ptr_e_s : comp_bank_q;
      err_d         = err_q | spurious_s;
      busy_d        = busy_q;
      layer_done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               num_tiles_d  = num_tiles;
               fetch_size_d = feature_size;
               fetch_cnt_d  = {CNT_W{1'b0}};
               comp_cnt_d   = {CNT_W{1'b0}};
               fetch_ptr_d  = 1'b0;
               comp_ptr_d   = 1'b0;
               err_d        = 1'b0;
               busy_d       = 1'b1;
            end else if (zero_s) begin
               layer_done_d = 1'b1;
            end else begin
               busy_d = 1'b0;
            end
         end
         ST_RUN: begin
            if (last_s) begin
               busy_d       = 1'b0;
               layer_done_d = 1'b1;
            end else begin
               busy_d = 1'b1;
            end
         end
         ST_FIN:  busy_d = 1'b0;
         default: busy_d = 1'b0;
      endcase
   end

   // State register; reset abandons any in-flight engine work.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         num_tiles_q   <= {CNT_W{1'b0}};
         fetch_cnt_q   <= {CNT_W{1'b0}};
         comp_cnt_q    <= {CNT_W{1'b0}};
         fetch_ptr_q   <= 1'b0;
         comp_ptr_q    <= 1'b0;
         fetch_fly_q   <= 1'b0;
         comp_fly_q    <= 1'b0;
         err_q         <= 1'b0;
         fetch_start_q <= 1'b0;
         fetch_bank_q  <= 1'b0;
         fetch_size_q  <= {SIZE_W{1'b0}};
         comp_start_q  <= 1'b0;
         comp_bank_q   <= 1'b0;
         busy_q        <= 1'b0;
         layer_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         num_tiles_q   <= num_tiles_d;
         fetch_cnt_q   <= fetch_cnt_d;
         comp_cnt_q    <= comp_cnt_d;
         fetch_ptr_q   <= fetch_ptr_d;
         comp_ptr_q    <= comp_ptr_d;
         fetch_fly_q   <= fetch_fly_d;
         comp_fly_q    <= comp_fly_d;
         err_q         <= err_d;
         fetch_start_q <= fetch_start_d;
         fetch_bank_q  <= fetch_bank_d;
         fetch_size_q  <= fetch_size_d;
         comp_start_q  <= comp_start_d;
         comp_bank_q   <= comp_bank_d;
         busy_q        <= busy_d;
         layer_done_q  <= layer_done_d;
      end
   end

   assign fetch_start = fetch_start_q;
   assign fetch_bank  = fetch_bank_q;
   assign fetch_size  = fetch_size_q;
   assign comp_start  = comp_start_q;
   assign comp_bank   = comp_bank_q;
   assign busy        = busy_q;
   assign layer_done  = layer_done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_feature_buf_ctrl.sv
// Scoreboard bench for feature_buf_ctrl with latency-programmable engine models.
module tb_feature_buf_ctrl;

   localparam int CNT_W  = 16;
   localparam int SIZE_W = 8;

   logic              clk = 1'b0;
   logic              rst, start, fetch_done, comp_done;
   logic [CNT_W-1:0]  num_tiles;
   logic [SIZE_W-1:0] feature_size;
   logic              fetch_start, fetch_bank, comp_start, comp_bank;
   logic              busy, layer_done, err;
   logic [SIZE_W-1:0] fetch_size;

   always #5 clk = ~clk;

   feature_buf_ctrl #(.CNT_W(CNT_W), .SIZE_W(SIZE_W)) dut (
      .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
      .feature_size(feature_size), .fetch_start(fetch_start),
      .fetch_bank(fetch_bank), .fetch_size(fetch_size), .fetch_done(fetch_done),
      .comp_start(comp_start), .comp_bank(comp_bank), .comp_done(comp_done),
      .busy(busy), .layer_done(layer_done), .err(err)
   );

   int n_pass = 0;
   int n_chk  = 0;
   int cyc = 0, start_cyc = 0;
   int f_due = -1, c_due = -1, fl = 10, cl = 20;
   int exp_size = 0, extra = 0;
   bit c_infl = 1'b0, c_bank_m = 1'b0, spur_c = 1'b0;
   bit rst_req = 1'b0, start_req = 1'b0;
   logic [CNT_W-1:0]  nt_req = '0;
   logic [SIZE_W-1:0] fs_req = '0;
   int exp_fb[$], exp_cb[$];
   int fs_cyc[$], cs_cyc[$], cdone_cyc[$], ld_cyc[$], both_q[$];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
   endtask

   // One clock: drive inputs after the edge, sample outputs on the falling edge.
   task automatic tick();
      @(posedge clk); #1;
      cyc++;
      rst          = rst_req;     rst_req   = 1'b0;
      start        = start_req;   start_req = 1'b0;
      num_tiles    = nt_req;
      feature_size = fs_req;
      fetch_done   = (cyc == f_due);
      comp_done    = (cyc == c_due) || spur_c;
      spur_c       = 1'b0;
      if (cyc == c_due) begin
         c_infl = 1'b0;
         cdone_cyc.push_back(cyc);
         if (cyc == f_due) both_q.push_back(cyc);
      end
      @(negedge clk);
      if (fetch_start) begin
         fs_cyc.push_back(cyc);
         f_due = cyc + fl;
         check_eq("fetch_busy", 32'(busy), 32'd1);
         check_eq("fetch_size", 32'(fetch_size), 32'(exp_size));
         if (c_infl) check_eq("bank_overlap", 32'(fetch_bank == c_bank_m), 32'd0);
         if (exp_fb.size() != 0) check_eq("fetch_bank", 32'(fetch_bank), 32'(exp_fb.pop_front()));
         else extra++;
      end
      if (comp_start) begin
         cs_cyc.push_back(cyc);
         c_due    = cyc + cl;
         c_infl   = 1'b1;
         c_bank_m = comp_bank;
         if (exp_cb.size() != 0) check_eq("comp_bank", 32'(comp_bank), 32'(exp_cb.pop_front()));
         else extra++;
      end
      if (layer_done) begin
         ld_cyc.push_back(cyc);
         check_eq("ld_busy", 32'(busy), 32'd0);
      end
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_fstart"}, 32'(fetch_start), 32'd0);
      check_eq({tag, "_fbank"},  32'(fetch_bank),  32'd0);
      check_eq({tag, "_fsize"},  32'(fetch_size),  32'd0);
      check_eq({tag, "_cstart"}, 32'(comp_start),  32'd0);
      check_eq({tag, "_cbank"},  32'(comp_bank),   32'd0);
      check_eq({tag, "_busy"},   32'(busy),        32'd0);
      check_eq({tag, "_ldone"},  32'(layer_done),  32'd0);
      check_eq({tag, "_err"},    32'(err),         32'd0);
   endtask

   // Drive a start pulse and push the expected bank sequence for the layer.
   task automatic start_layer(input int n, input int size, input int f_lat, input int c_lat);
      fl = f_lat; cl = c_lat; exp_size = size; extra = 0;
      exp_fb.delete(); exp_cb.delete(); fs_cyc.delete(); cs_cyc.delete();
      cdone_cyc.delete(); ld_cyc.delete(); both_q.delete();
      for (int i = 0; i < n; i++) begin
         exp_fb.push_back(i % 2);
         exp_cb.push_back(i % 2);
      end
      start_req = 1'b1; nt_req = CNT_W'(n); fs_req = SIZE_W'(size);
      tick();
      start_cyc = cyc;
      tick();
      check_eq("busy_after_start", 32'(busy), 32'(n != 0));
      if (n != 0) check_eq("err_cleared", 32'(err), 32'd0);
   endtask

   task automatic finish_layer(input string tag, input int n, input int limit);
      int g = 0;
      while (ld_cyc.size() == 0 && g < limit) begin
         tick();
         g++;
      end
      repeat (3) tick();
      check_eq({tag, "_ld_count"},   32'(ld_cyc.size()), 32'd1);
      check_eq({tag, "_fetch_cnt"},  32'(fs_cyc.size()), 32'(n));
      check_eq({tag, "_comp_cnt"},   32'(cs_cyc.size()), 32'(n));
      check_eq({tag, "_extra"},      32'(extra),         32'd0);
      if (ld_cyc.size() != 0) begin
         if (n == 0) check_eq({tag, "_ld_lat"}, 32'(ld_cyc[0]), 32'(start_cyc + 1));
         else if (cdone_cyc.size() != 0)
            check_eq({tag, "_ld_lat"}, 32'(ld_cyc[0]), 32'(cdone_cyc[$] + 1));
      end
      if (n != 0 && fs_cyc.size() != 0)
         check_eq({tag, "_first_fetch"}, 32'(fs_cyc[0]), 32'(start_cyc + 2));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; fetch_done = 1'b0; comp_done = 1'b0;
      num_tiles = '0; feature_size = '0;
      rst_req = 1'b1;
      tick();
      tick();
      check_idle("reset");

      // Basic layer: 3 tiles, fetch 10, compute 20.
      start_layer(3, 32, 10, 20);
      finish_layer("basic", 3, 400);

      // Slow compute: third fetch waits on the first release.
      start_layer(4, 16, 10, 50);
      finish_layer("slow", 4, 800);
      if (fs_cyc.size() > 2 && cdone_cyc.size() > 0)
         check_eq("slow_fetch3", 32'(fs_cyc[2]), 32'(cdone_cyc[0] + 1));

      // Equal latencies force simultaneous fetch_done/comp_done.
      start_layer(4, 8, 10, 10);
      finish_layer("both", 4, 400);
      check_eq("both_seen", 32'(both_q.size() != 0), 32'd1);
      if (both_q.size() != 0 && fs_cyc.size() > 2 && cs_cyc.size() > 1) begin
         check_eq("both_fetch_next", 32'(fs_cyc[2]), 32'(both_q[0] + 1));
         check_eq("both_comp_next",  32'(cs_cyc[1]), 32'(both_q[0] + 1));
      end

      // Zero-tile layer.
      start_layer(0, 5, 10, 10);
      finish_layer("zero", 0, 20);

      // A second start while busy is ignored.
      start_layer(2, 12, 10, 20);
      repeat (5) tick();
      start_req = 1'b1; nt_req = CNT_W'(5); fs_req = SIZE_W'(99);
      finish_layer("ignore", 2, 400);

      // Spurious comp_done in IDLE sets the sticky error only.
      spur_c = 1'b1;
      tick();
      tick();
      check_eq("spur_err",    32'(err),         32'd1);
      check_eq("spur_busy",   32'(busy),        32'd0);
      check_eq("spur_fstart", 32'(fetch_start), 32'd0);
      check_eq("spur_ldone",  32'(layer_done),  32'd0);
      start_layer(2, 20, 10, 20);
      finish_layer("after_err", 2, 400);

      // Reset while a fetch and a compute are both in flight.
      start_layer(3, 32, 10, 20);
      for (int g = 0; g < 100 && cs_cyc.size() == 0; g++) tick();
      tick();
      tick();
      check_eq("mid_both_fly", 32'(c_infl && (f_due > cyc)), 32'd1);
      rst_req = 1'b1;
      tick();
      f_due = -1; c_due = -1; c_infl = 1'b0;
      tick();
      check_idle("rst_mid");
      start_layer(3, 40, 10, 20);
      finish_layer("post_rst", 3, 400);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
